// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divide sequencer.
package div_pkg;

  localparam int DIV_STEPS = 32;
  localparam int DIV_CNT_W = 6;

  // ALU control codes used by the EX decoder for DIV / DIVU.
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  // Quotient reported for a zero divisor.
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_t;

  // Absolute value when the operand is treated as signed, raw value otherwise.
  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_sched_if.sv
// EX-side request and result signals of the divide sequencer.
interface div_sched_if;
  logic        ex_valid_i;
  logic [4:0]  ex_alucontrol_i;
  logic [31:0] ex_srca_i;
  logic [31:0] ex_srcb_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic        div_stall_o;
  logic        div_ready_o;
  logic [31:0] div_hi_o;
  logic [31:0] div_lo_o;

  // Pipeline side: issues divides, consumes stall and results.
  modport master (
    output ex_valid_i, ex_alucontrol_i, ex_srca_i, ex_srcb_i, flush_i, ex_stall_i,
    input  div_stall_o, div_ready_o, div_hi_o, div_lo_o
  );

  // Sequencer side.
  modport slave (
    input  ex_valid_i, ex_alucontrol_i, ex_srca_i, ex_srcb_i, flush_i, ex_stall_i,
    output div_stall_o, div_ready_o, div_hi_o, div_lo_o
  );
endinterface

// File: rtl/div_iter_core.sv
// Restoring-division datapath: one quotient bit per step on unsigned magnitudes.
module div_iter_core
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] rem,
  output logic [31:0] quo
);

  logic [63:0] acc_reg;
  logic [31:0] dvsr_reg;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;

  // The shifted partial remainder can reach 2*divisor-1, so compare in 33 bits;
  // bit 32 of the difference is the borrow (remainder smaller than divisor).
  assign rem_shift = acc_reg[63:31];
  assign rem_diff  = rem_shift - {1'b0, dvsr_reg};

  // Load the operands, then shift/compare/subtract once per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg  <= '0;
      dvsr_reg <= '0;
    end else if (load) begin
      acc_reg  <= {32'd0, dividend};
      dvsr_reg <= divisor;
    end else if (step) begin
      if (!rem_diff[32])
        acc_reg <= {rem_diff[31:0], acc_reg[30:0], 1'b1};
      else
        acc_reg <= {rem_shift[31:0], acc_reg[30:0], 1'b0};
    end
  end

  assign rem = acc_reg[63:32];
  assign quo = acc_reg[31:0];

endmodule

// File: rtl/div_sched.sv
// Multi-cycle DIV/DIVU sequencer for EX: stalls the pipe while iterating,
// holds HI/LO until EX advances, and aborts on flush.
module div_sched
  import div_pkg::*;
#(
  parameter bit         EARLY_ZERO = 1'b1,
  parameter logic [4:0] DIV_CODE   = DIV_CONTROL,
  parameter logic [4:0] DIVU_CODE  = DIVU_CONTROL
) (
  input logic        clk,
  input logic        rst,
  div_sched_if.slave bus
);

  div_state_t           state_reg;
  logic [DIV_CNT_W-1:0] cnt_reg;
  logic                 signed_reg;
  logic                 neg_quo_reg;
  logic                 neg_rem_reg;
  logic [31:0]          hi_reg;
  logic [31:0]          lo_reg;

  logic        req;
  logic        is_signed;
  logic        zero_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] core_rem;
  logic [31:0] core_quo;
  logic        core_load;
  logic        core_step;

  assign is_signed = (bus.ex_alucontrol_i == DIV_CODE);
  assign req       = bus.ex_valid_i && !bus.flush_i &&
                     ((bus.ex_alucontrol_i == DIV_CODE) || (bus.ex_alucontrol_i == DIVU_CODE));
  assign zero_div  = EARLY_ZERO && (bus.ex_srcb_i == 32'd0);
  assign a_mag     = mag_of(bus.ex_srca_i, is_signed);
  assign b_mag     = mag_of(bus.ex_srcb_i, is_signed);

  assign core_load = (state_reg == IDLE) && req;
  assign core_step = (state_reg == BUSY) && !bus.flush_i;

  div_iter_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .rem      (core_rem),
    .quo      (core_quo)
  );

  // Control FSM with step counter, operand-sign capture and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      signed_reg  <= 1'b0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (bus.flush_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            signed_reg  <= is_signed;
            neg_quo_reg <= bus.ex_srca_i[31] ^ bus.ex_srcb_i[31];
            neg_rem_reg <= bus.ex_srca_i[31];
            cnt_reg     <= '0;
            if (zero_div) begin
              lo_reg    <= DIV_ZERO_QUO;
              hi_reg    <= bus.ex_srca_i;
              state_reg <= DONE;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == DIV_CNT_W'(DIV_STEPS - 1))
            state_reg <= FIX;
        end
        FIX: begin
          lo_reg    <= (signed_reg && neg_quo_reg) ? (32'd0 - core_quo) : core_quo;
          hi_reg    <= (signed_reg && neg_rem_reg) ? (32'd0 - core_rem) : core_rem;
          state_reg <= DONE;
        end
        DONE: begin
          if (!bus.ex_stall_i)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle and the whole iteration; DONE lets EX advance.
  assign bus.div_stall_o = ((state_reg == IDLE) && req) || (state_reg == BUSY) || (state_reg == FIX);
  assign bus.div_ready_o = (state_reg == DONE);
  assign bus.div_hi_o    = hi_reg;
  assign bus.div_lo_o    = lo_reg;

endmodule
